// File: rtl/led_share_arbiter.sv
// Round-robin owner of the 8-LED bank with tick-based hold/max limits and a one-tick blank gap.
// Optional idle heartbeat counter on led when LED_ARB_IDLE_COUNT_EN is defined.
module led_share_arbiter #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned TICK_DIV   = 500000,
   parameter int unsigned HOLD_TICKS = 12,
   parameter int unsigned MAX_TICKS  = 48
) (
   input  logic                 clock_12mhz,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] pattern,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           led,
   output logic                 tick,
   output logic                 busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(MAX_TICKS + 1);

   typedef enum logic [1:0] {IDLE, GRANT, BLANK} state_t;

   state_t             state, state_nxt;
   logic [PW-1:0]      count;
   logic [HW-1:0]      hold, hold_nxt;
   logic [IW-1:0]      last, last_nxt, win;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [7:0]         led_nxt;
   logic               any_req, drop, found;
   logic               blank_first, blank_tick;

   always_ff @(posedge clock_12mhz or negedge reset_n) begin
      if (!reset_n)                         count <= '0;
      else if (count == PW'(TICK_DIV - 1))  count <= '0;
      else                                  count <= count + PW'(1);
   end

   assign tick = (count == PW'(TICK_DIV - 1));

   // Scan starts just past the previous owner, so that owner is considered last.
   always_comb begin
      win   = last;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!found && req[IW'((32'(last) + k) % NUM_REQ)]) begin
            found = 1'b1;
            win   = IW'((32'(last) + k) % NUM_REQ);
         end
      end
   end

   assign any_req    = |req;
   assign drop       = !req[last]
                    || ((hold >= HW'(HOLD_TICKS)) && (|(req & ~grant)))
                    || (hold == HW'(MAX_TICKS));
   // The tick coinciding with the blank entry cycle must not end the gap.
   assign blank_tick = (state == BLANK) && tick && !blank_first;
   assign busy       = (state != IDLE);

`ifdef LED_ARB_IDLE_COUNT_EN
   logic [7:0] idle_cnt;

   always_ff @(posedge clock_12mhz or negedge reset_n) begin
      if (!reset_n)                     idle_cnt <= '0;
      else if (state == IDLE && tick)   idle_cnt <= idle_cnt + 8'd1;
   end
`endif

   always_ff @(posedge clock_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         grant       <= '0;
         led         <= '0;
         hold        <= '0;
         last        <= IW'(NUM_REQ - 1);
         blank_first <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         led         <= led_nxt;
         hold        <= hold_nxt;
         last        <= last_nxt;
         blank_first <= (state != BLANK) && (state_nxt == BLANK);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = GRANT;
         GRANT:   if (drop) state_nxt = BLANK;
         BLANK:   if (blank_tick) state_nxt = any_req ? GRANT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_nxt = '0;
      led_nxt   = '0;
      hold_nxt  = hold;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = NUM_REQ'(1) << win;
               last_nxt  = win;
               hold_nxt  = '0;
            end
`ifdef LED_ARB_IDLE_COUNT_EN
            else begin
               led_nxt = tick ? idle_cnt + 8'd1 : idle_cnt;
            end
`endif
         end
         GRANT: begin
            if (!drop) begin
               grant_nxt = grant;
               led_nxt   = pattern[{last, 3'b000} +: 8];
               if (tick && hold != HW'(MAX_TICKS)) hold_nxt = hold + HW'(1);
            end
         end
         BLANK: begin
            if (blank_tick && any_req) begin
               grant_nxt = NUM_REQ'(1) << win;
               last_nxt  = win;
               hold_nxt  = '0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_led_share_arbiter.sv
// Randomised and directed bench for led_share_arbiter against an integer-level reference model.
module tb_led_share_arbiter;

   localparam int N    = 3;
   localparam int TD   = 4;
   localparam int HT   = 2;
   localparam int MT   = 5;
   localparam int PWID = 8 * N;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [PWID-1:0] pattern = '0;
   logic [N-1:0]    grant;
   logic [7:0]      led;
   logic            tick;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner index (-1 = none), blank flag, gap armed flag, counters.
   int         m_owner, m_blank, m_armed, m_hold, m_ptr, m_cnt;
   logic [7:0] m_led;

   led_share_arbiter #(
      .NUM_REQ    (N),
      .TICK_DIV   (TD),
      .HOLD_TICKS (HT),
      .MAX_TICKS  (MT)
   ) dut (
      .clock_12mhz (clk),
      .reset_n     (rst_n),
      .req         (req),
      .pattern     (pattern),
      .grant       (grant),
      .led         (led),
      .tick        (tick),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int r, input int from);
      for (int k = 1; k <= N; k++) begin
         if (((r >> ((from + k) % N)) & 1) != 0) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_blank = 0;
      m_armed = 0;
      m_hold  = 0;
      m_ptr   = N - 1;
      m_cnt   = 0;
      m_led   = 8'h00;
   endtask

   task automatic model_edge(input int r, input logic [PWID-1:0] p);
      int tk;
      int others;
      tk    = (m_cnt == TD - 1) ? 1 : 0;
      m_cnt = (m_cnt + 1) % TD;
      if (m_owner >= 0) begin
         others = r & ~(1 << m_owner);
         if ((((r >> m_owner) & 1) == 0) || (m_hold >= HT && others != 0) || m_hold == MT) begin
            m_owner = -1;
            m_blank = 1;
            m_armed = 0;
            m_led   = 8'h00;
         end else begin
            m_led = 8'(p >> (8 * m_owner));
            if (tk == 1 && m_hold < MT) m_hold++;
         end
      end else if (m_blank != 0) begin
         if (m_armed != 0 && tk == 1) begin
            m_blank = 0;
            m_owner = rr_pick(r, m_ptr);
            if (m_owner >= 0) begin
               m_ptr  = m_owner;
               m_hold = 0;
            end
         end else begin
            m_armed = 1;
         end
      end else begin
         m_owner = rr_pick(r, m_ptr);
         if (m_owner >= 0) begin
            m_ptr  = m_owner;
            m_hold = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int eg;
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      check_val({tag, "_grant"}, 32'(grant), eg);
      check_val({tag, "_led"}, 32'(led), 32'(m_led));
      check_val({tag, "_tick"}, 32'(tick), (m_cnt == TD - 1) ? 1 : 0);
      check_val({tag, "_busy"}, 32'(busy), (m_owner >= 0 || m_blank != 0) ? 1 : 0);
      check_val({tag, "_onehot"}, 32'($onehot0(grant)), 1);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge(int'(req), pattern);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_reset();
      repeat (n) @(posedge clk);
      #1;
      check_all("rst");
      #2 rst_n = 1'b1;
   endtask

   logic [N-1:0] prev_grant;
   int           seq[$];
   int           exp_seq[4] = '{1, 2, 4, 1};

   initial begin
      // 1: reset and first tick
      do_reset(3);
      cycle("s1");
      cycle("s1");
      check_val("s1_no_tick_yet", 32'(tick), 0);
      cycle("s1");
      check_val("s1_first_tick", 32'(tick), 1);

      // 2: single request from idle
      pattern = 24'h00A500;
      req     = 3'b010;
      cycle("s2");
      check_val("s2_grant", 32'(grant), 32'h2);
      cycle("s2");
      check_val("s2_led", 32'(led), 32'hA5);
      req = '0;
      repeat (12) cycle("s2");

      // 3: contention after one tick, owner held until hold reaches HOLD_TICKS
      pattern = 24'h5A_00_C3;
      req     = 3'b001;
      repeat (6) cycle("s3");
      req = 3'b101;
      repeat (30) cycle("s3");
      req = '0;
      repeat (12) cycle("s3");

      // 4: lone requester forced off at MAX_TICKS and re-granted
      req = 3'b001;
      repeat (60) cycle("s4");
      req = '0;
      repeat (12) cycle("s4");

      // 5: all requesting from reset, round-robin order
      do_reset(2);
      req        = 3'b111;
      prev_grant = '0;
      repeat (80) begin
         cycle("s5");
         if (grant != '0 && prev_grant == '0) seq.push_back(int'(grant));
         prev_grant = grant;
      end
      for (int i = 0; i < 4; i++)
         check_val("s5_rr_order", (i < seq.size()) ? 32'(seq[i]) : 32'h0, 32'(exp_seq[i]));
      req = '0;
      repeat (12) cycle("s5");

      // 6: asynchronous reset mid-grant
      pattern = 24'h00_00_3C;
      req     = 3'b001;
      for (int i = 0; i < 20 && m_led != 8'h3C; i++) cycle("s6");
      check_val("s6_led_before", 32'(led), 32'h3C);
      #2 rst_n = 1'b0;
      #1;
      check_val("s6_async_grant", 32'(grant), 32'h0);
      check_val("s6_async_led", 32'(led), 32'h0);
      check_val("s6_async_busy", 32'(busy), 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      req = 3'b111;
      cycle("s6");
      check_val("s6_first_winner", 32'(grant), 32'h1);
      req = '0;
      repeat (12) cycle("s6");

      // Randomised traffic with slowly changing requests
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(5, 0) == 0) req = req ^ N'(1 << $urandom_range(N - 1, 0));
         if ($urandom_range(2, 0) == 0) pattern = PWID'($urandom);
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
